pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
Parametrised N-bit adder/subtractor. The carry chain is split into STAGES equal slices, with one pipeline register per slice, so timing closes at wide N. Each slice is a gate-level ripple-carry chain of W = N/STAGES full adders. The carry between slices is registered. A valid/ready handshake on both sides sustains one operation per cycle with backpressure. It replaces the single-cycle combinational adder in datapaths where N is too wide for one cycle.

Parameters:
N, 16, operand/result width in bits; must be ≥ 1.
STAGES, 4, number of pipeline slices; 1 ≤ STAGES ≤ N, and N % STAGES == 0 (elaboration error otherwise).

Ports:
clk  input  1  clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand beat valid.
in_ready  output  1  block accepts beat this cycle.
a  input  N  operand A.
b  input  N  operand B.
cin  input  1  carry-in (add) / borrow-in (sub).
sub  input  1  0 = add, 1 = subtract.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
s  output  N  sum/difference.
cout  output  1  raw carry-out of the MSB.
ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset is asynchronous and active-low; one clock domain.
- While rst_n = 0, all stage valid bits clear; out_valid = 0, s = 0, cout = 0, ovf = 0. Data registers also clear to 0.
- Arithmetic:
  - Effective B: b XOR {N{sub}}. Effective carry-in: cin XOR sub.
  - sub=0: s = a + b + cin.
  - sub=1: s = a − b − cin. cout = 1 means no borrow.
  - Result is taken modulo 2^N. cout is the carry out of bit N−1 of the effective addition.
  - ovf = (A[N−1] == effB[N−1]) && (s[N−1] != A[N−1]).
- Pipeline:
  - Stage k (0..STAGES−1) adds bits [k·W +: W] using the carry registered by stage k−1. Stage 0 uses the effective carry-in.
  - Upper operand slices are delayed by skew registers. Lower result slices are delayed by de-skew registers, so all N result bits emerge together.
  - MSB sign bits for ovf are carried alongside the data.
- Global stall:
  - advance = !out_valid || out_ready.
  - in_ready = advance. This is a combinational path from out_ready and out_valid only, not from in_valid.
  - A beat is accepted when in_valid && in_ready.
  - When advance = 1, every stage register (valid and data) shifts one stage. Stage 0 loads the input beat; its valid bit = in_valid.
  - When advance = 0, all registers hold.
- Latency: exactly STAGES cycles from the accepting edge to out_valid = 1, given no stall.
- Throughput: one result per cycle with out_ready held high.
- Output stability: while out_valid && !out_ready, s, cout and ovf hold unchanged until accepted.
- Bubbles: empty stages shift like any other; there is no bubble collapsing. A bubble reaching the output yields out_valid = 0.
- Ordering: results are produced strictly in input order. No beat is dropped or duplicated under any in_valid/out_ready pattern.
- Simultaneous accept at input and output in the same cycle is allowed; the pipeline shifts normally.
- Reset mid-operation: all in-flight beats are discarded. out_valid drops asynchronously to 0, and no stale result appears after rst_n deasserts.
- STAGES=1: a single registered N-bit adder with latency 1.
- STAGES=N: W=1, one full adder per stage.

Test Plan:
1. N=16, STAGES=4, out_ready=1, one beat a=0xFFFF, b=0x0001, cin=0, sub=0.
   -> After exactly 4 cycles: out_valid=1, s=0x0000, cout=1, ovf=0. The carry propagates through all 4 slice registers.
2. Subtract, sub=1:
   - a=0x8000, b=0x0001, cin=0 -> s=0x7FFF, cout=1, ovf=1.
   - a=0x0003, b=0x0005, cin=1 -> s=0xFFFD, cout=0, ovf=0.
3. 100 back-to-back random beats, in_valid=1, out_ready=1.
   -> in_ready stays 1 and out_valid is high for 100 consecutive cycles, starting 4 cycles after the first accept.
   -> Results match the reference model in order.
4. Backpressure:
   - Pipeline holds 4 valid beats; drop out_ready for 5 cycles.
   - -> in_ready=0 and s/cout/ovf are stable throughout. Re-raising out_ready drains all 4 beats in order with no loss or duplication.
   - Then drive random toggling of in_valid/out_ready for 1000 cycles -> scoreboard passes.
5. Reset mid-flight: assert rst_n=0 with 3 beats in flight, between clock edges.
   - -> out_valid=0 and s=0 immediately.
   - -> After release, no result appears until a new beat is accepted, and that result arrives 4 cycles later.
6. Parameter sweep: (N,STAGES) = (16,1), (16,16), (32,8), (7,7).
   -> Latency equals STAGES. Exhaustive or random add/sub with random cin matches the reference model, including cout and ovf.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined N-bit adder/subtractor: STAGES ripple-carry slices with a registered
// inter-slice carry, operand skew / result de-skew, and a global valid/ready stall.
module pipelined_adder #(
  parameter int unsigned N      = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf
);

  localparam int unsigned SDIV = (STAGES == 0) ? 1 : STAGES;
  localparam int unsigned W    = N / SDIV;

  if (N < 1 || STAGES < 1 || STAGES > N || (N % SDIV) != 0) begin : g_bad_params
    $error("pipelined_adder: N must be >= 1, 1 <= STAGES <= N and N divisible by STAGES");
  end

  logic [N-1:0] effb;
  logic         advance;

  // Per-stage registers. res_q[k] holds finished sum slices 0..k and the
  // still-unused A slices above; opb_q[k] skews the effective B alongside.
  logic         vld_q  [STAGES];
  logic         cry_q  [STAGES];
  logic         amsb_q [STAGES];
  logic         bmsb_q [STAGES];
  logic [N-1:0] res_q  [STAGES];
  logic [N-1:0] opb_q  [STAGES];

  logic [N-1:0] res_d  [STAGES];
  logic         cry_d  [STAGES];

  assign effb = b ^ {N{sub}};

  // Gate-level ripple of W full adders over slice k; other bits pass through.
  function automatic logic [N:0] slice_add(input logic [N-1:0] ra,
                                           input logic [N-1:0] rb,
                                           input logic         ci,
                                           input int unsigned  k);
    logic [N-1:0] r;
    logic         c;
    r = ra;
    c = ci;
    for (int unsigned i = 0; i < W; i++) begin
      r[k*W + i] = ra[k*W + i] ^ rb[k*W + i] ^ c;
      c = (ra[k*W + i] & rb[k*W + i]) | (c & (ra[k*W + i] ^ rb[k*W + i]));
    end
    return {c, r};
  endfunction

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      res_d[k] = '0;
      cry_d[k] = 1'b0;
    end
    {cry_d[0], res_d[0]} = slice_add(a, effb, cin ^ sub, 0);
    for (int unsigned k = 1; k < STAGES; k++) begin
      {cry_d[k], res_d[k]} = slice_add(res_q[k-1], opb_q[k-1], cry_q[k-1], k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        vld_q[k]  <= 1'b0;
        cry_q[k]  <= 1'b0;
        amsb_q[k] <= 1'b0;
        bmsb_q[k] <= 1'b0;
        res_q[k]  <= '0;
        opb_q[k]  <= '0;
      end
    end else if (advance) begin
      vld_q[0]  <= in_valid;
      opb_q[0]  <= effb;
      amsb_q[0] <= a[N-1];
      bmsb_q[0] <= effb[N-1];
      for (int unsigned k = 1; k < STAGES; k++) begin
        vld_q[k]  <= vld_q[k-1];
        opb_q[k]  <= opb_q[k-1];
        amsb_q[k] <= amsb_q[k-1];
        bmsb_q[k] <= bmsb_q[k-1];
      end
      for (int unsigned k = 0; k < STAGES; k++) begin
        res_q[k] <= res_d[k];
        cry_q[k] <= cry_d[k];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign s         = res_q[STAGES-1];
  assign cout      = cry_q[STAGES-1];
  assign ovf       = (amsb_q[STAGES-1] == bmsb_q[STAGES-1]) && (s[N-1] != amsb_q[STAGES-1]);

  // Whole pipe moves as one; in_ready deliberately ignores in_valid.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed vector table, back-to-back stream,
// backpressure, mid-flight reset, and a parameter sweep of extra instances.
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rst_sw = 1'b1;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, s;
  logic        cin, sub, cout, ovf;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  int unsigned popped = 0;
  int unsigned sw_done = 0;
  logic [17:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_adder #(.N(16), .STAGES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc, input logic ms);
    logic [15:0] eb;
    logic [16:0] t;
    logic        ov;
    eb = mb ^ {16{ms}};
    t  = {1'b0, ma} + {1'b0, eb} + {16'd0, mc ^ ms};
    ov = (ma[15] == eb[15]) && (t[15] != ma[15]);
    return {ov, t[16], t[15:0]};
  endfunction

  // One cycle: drive at negedge, then check output against scoreboard head
  // and record an accepted beat.
  task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                      input logic ic, input logic isub, input logic ordy,
                      input logic [17:0] ex);
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; cin = ic; sub = isub; out_ready = ordy;
    #1;
    if (out_valid) begin
      if (sb.size() == 0) chk("unexpected_out", 64'(out_valid), 64'd0);
      else begin
        chk("result", 64'({ovf, cout, s}), 64'(sb[0]));
        if (out_ready) begin
          void'(sb.pop_front());
          popped++;
        end
      end
    end
    if (in_valid && in_ready) sb.push_back(ex);
  endtask

  task automatic one_beat(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                          input logic isub, input logic [17:0] ex, input string nm);
    int unsigned t0;
    int unsigned n;
    step(1'b1, ia, ib, ic, isub, 1'b1, ex);
    chk({nm, "_accept"}, 64'(in_ready), 64'd1);
    t0 = cyc;
    n  = 0;
    while (!out_valid && n < 20) begin
      step(1'b0, ia, ib, ic, isub, 1'b1, 18'd0);
      n++;
    end
    chk({nm, "_lat"}, 64'(cyc - t0), 64'd4);
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        cout, ovf;
  } vec_t;

  initial begin
    vec_t        tv[12];
    logic [15:0] ra, rb;
    logic        rc, rs;
    logic [17:0] exb0, ex5;
    int unsigned t0, first, last, run, p0;
    logic        seen, rdy_ok;

    tv[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tv[1]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tv[2]  = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0};
    tv[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tv[4]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    tv[5]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tv[6]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    tv[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tv[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tv[9]  = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tv[10] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    tv[11] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};

    in_valid = 1'b1; out_ready = 1'b0; a = 16'hFFFF; b = 16'h0001; cin = 1'b1; sub = 1'b0;
    #1;
    rst_n = 1'b0;
    rst_sw = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_s", 64'(s), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    rst_sw = 1'b1;

    for (int i = 0; i < 12; i++)
      one_beat(tv[i].a, tv[i].b, tv[i].cin, tv[i].sub, {tv[i].ovf, tv[i].cout, tv[i].s},
               $sformatf("vec%0d", i));

    // Back-to-back stream
    seen = 1'b0; rdy_ok = 1'b1; run = 0; first = 0; last = 0; t0 = 0;
    for (int i = 0; i < 110; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      step(i < 100, ra, rb, rc, rs, 1'b1, model(ra, rb, rc, rs));
      if (i == 0) t0 = cyc;
      if (i < 100 && !in_ready) rdy_ok = 1'b0;
      if (out_valid) begin
        if (!seen) begin
          seen  = 1'b1;
          first = cyc;
        end
        run++;
        last = cyc;
      end
    end
    chk("b2b_first_lat", 64'(first - t0), 64'd4);
    chk("b2b_count", 64'(run), 64'd100);
    chk("b2b_contig", 64'(last - first), 64'd99);
    chk("b2b_in_ready", 64'(rdy_ok), 64'd1);

    // Backpressure: fill four beats, stall five cycles with a fifth beat pending
    p0 = popped;
    exb0 = 18'd0;
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      if (i == 0) exb0 = model(ra, rb, rc, rs);
      step(1'b1, ra, rb, rc, rs, 1'b0, model(ra, rb, rc, rs));
    end
    ra = 16'h5A5A; rb = 16'h0F0F; rc = 1'b1; rs = 1'b1;
    ex5 = model(ra, rb, rc, rs);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, ra, rb, rc, rs, 1'b0, ex5);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_hold", 64'({ovf, cout, s}), 64'(exb0));
    end
    for (int i = 0; i < 12 && (i == 0 || sb.size() != 0); i++)
      step(i == 0, ra, rb, rc, rs, 1'b1, ex5);
    chk("bp_drained", 64'(popped - p0), 64'd5);
    chk("bp_empty", 64'(sb.size()), 64'd0);

    // Random valid/ready toggling
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), ra, rb, rc, rs, 1'($urandom_range(0, 1)),
           model(ra, rb, rc, rs));
    end
    for (int i = 0; i < 30 && sb.size() != 0; i++)
      step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 18'd0);
    chk("rand_drain_empty", 64'(sb.size()), 64'd0);

    // Reset with three beats in flight
    step(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, model(16'h1111, 16'h2222, 1'b0, 1'b0));
    step(1'b1, 16'h0ABC, 16'h0123, 1'b1, 1'b1, 1'b1, model(16'h0ABC, 16'h0123, 1'b1, 1'b1));
    step(1'b1, 16'h4000, 16'h4000, 1'b0, 1'b0, 1'b1, model(16'h4000, 16'h4000, 1'b0, 1'b0));
    step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 18'd0);
    step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 18'd0);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_s", 64'(s), 64'd0);
    chk("midrst_cout", 64'(cout), 64'd0);
    chk("midrst_ovf", 64'(ovf), 64'd0);
    sb.delete();
    @(negedge clk); @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 18'd0);
      chk("post_rst_idle", 64'(out_valid), 64'd0);
    end
    one_beat(16'h0102, 16'h0304, 1'b0, 1'b0, 18'h00406, "post_rst");

    for (int i = 0; i < 1000 && sw_done < 4; i++) @(negedge clk);
    chk("sweep_done", 64'(sw_done), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Parameter sweep: streaming random add/sub, checking value and latency
  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int unsigned PN = (g == 0) ? 16 : (g == 1) ? 16 : (g == 2) ? 32 : 7;
    localparam int unsigned PS = (g == 0) ? 1  : (g == 1) ? 16 : (g == 2) ? 8  : 7;

    logic          sv, sir, sov, sor, scin, ssub, scout, sovf;
    logic [PN-1:0] sa, sbv, ss;
    logic [PN+1:0] eq[$];
    int unsigned   tq[$];

    pipelined_adder #(.N(PN), .STAGES(PS)) u_sw (
      .clk(clk), .rst_n(rst_sw), .in_valid(sv), .in_ready(sir),
      .a(sa), .b(sbv), .cin(scin), .sub(ssub),
      .out_valid(sov), .out_ready(sor),
      .s(ss), .cout(scout), .ovf(sovf)
    );

    initial begin
      logic [PN-1:0] eb;
      logic [PN:0]   t;
      logic          ov;
      sv = 1'b0; sor = 1'b1; sa = '0; sbv = '0; scin = 1'b0; ssub = 1'b0;
      wait (rst_sw === 1'b0);
      wait (rst_sw === 1'b1);
      for (int i = 0; i < 60 + int'(PS) + 4; i++) begin
        @(negedge clk);
        sv = (i < 60); sa = PN'($urandom); sbv = PN'($urandom);
        scin = 1'($urandom_range(0, 1)); ssub = 1'($urandom_range(0, 1)); sor = 1'b1;
        #1;
        if (sov) begin
          if (eq.size() == 0) chk($sformatf("sw%0d_unexpected", g), 64'(sov), 64'd0);
          else begin
            chk($sformatf("sw%0d_result", g), 64'({sovf, scout, ss}), 64'(eq[0]));
            chk($sformatf("sw%0d_lat", g), 64'(cyc - tq[0]), 64'(PS));
            void'(eq.pop_front());
            void'(tq.pop_front());
          end
        end
        if (sv && sir) begin
          eb = sbv ^ {PN{ssub}};
          t  = {1'b0, sa} + {1'b0, eb} + {{PN{1'b0}}, scin ^ ssub};
          ov = (sa[PN-1] == eb[PN-1]) && (t[PN-1] != sa[PN-1]);
          eq.push_back({ov, t[PN], t[PN-1:0]});
          tq.push_back(cyc);
        end
      end
      chk($sformatf("sw%0d_empty", g), 64'(eq.size()), 64'd0);
      sw_done++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
